timer_ctrl: RTL and testbench

TIMER_CTRL -- requirements
Module: timer_ctrl

---
 rtl/timer_ctrl_if.sv | 24 ++
 rtl/timer_ctrl.sv | 103 ++++++++++
 tb/tb_timer_ctrl.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/timer_ctrl_if.sv
// Control bus between the timer sequencer and its digit counters.
interface timer_ctrl_if #(
    parameter int NUM_DIGITS = 4
);
    logic                  tick;
    logic                  start;
    logic                  stop;
    logic [NUM_DIGITS-1:0] tc;
    logic [NUM_DIGITS-1:0] digit_en;
    logic                  cnt_clear;
    logic                  running;
    logic                  alarm;
    logic [1:0]            state;

    modport master (
        output tick, start, stop, tc,
        input  digit_en, cnt_clear, running, alarm, state
    );

    modport slave (
        input  tick, start, stop, tc,
        output digit_en, cnt_clear, running, alarm, state
    );
endinterface

// File: rtl/timer_ctrl.sv
// Countdown timer sequencer driving cascaded down-counting digits.
// Define ALARM_TIMEOUT_EN to auto-clear the alarm after ALARM_TICKS ticks.
module timer_ctrl #(
    parameter int NUM_DIGITS  = 4,
    parameter int ALARM_TICKS = 30
) (
    input logic clk,
    input logic reset,
    timer_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10,
        DONE  = 2'b11
    } state_t;

    state_t                st;
    logic                  clr;
    logic                  all_zero;
    logic                  run_tick;
    logic                  done_hit;
    logic                  carry;
    logic [NUM_DIGITS-1:0] en;

    if (ALARM_TICKS < 1 || ALARM_TICKS > 255) begin : g_bad_ticks
        $error("ALARM_TICKS must be within 1..255");
    end

    assign all_zero = &bus.tc;
    assign run_tick = (st == RUN) & bus.tick & ~clr;
    assign done_hit = run_tick & all_zero;

    // Ripple the enable through each digit that is sitting at zero.
    always_comb begin
        en    = '0;
        carry = run_tick & ~all_zero;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            en[i] = carry;
            carry = carry & bus.tc[i];
        end
    end

`ifdef ALARM_TIMEOUT_EN
    localparam logic [7:0] ALARM_LAST = 8'(ALARM_TICKS - 1);
    logic [7:0] acnt;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            st  <= IDLE;
            clr <= 1'b0;
`ifdef ALARM_TIMEOUT_EN
            acnt <= 8'd0;
`endif
        end else begin
            clr <= 1'b0;
            unique case (st)
                IDLE: begin
                    if (bus.start && !bus.stop) begin
                        st  <= RUN;
                        clr <= 1'b1;
                    end
                end
                RUN: begin
                    if (bus.stop) begin
                        st <= PAUSE;
                    end else if (done_hit) begin
                        st <= DONE;
`ifdef ALARM_TIMEOUT_EN
                        acnt <= 8'd0;
`endif
                    end
                end
                PAUSE: begin
                    if (bus.stop) begin
                        st <= IDLE;
                    end else if (bus.start) begin
                        st <= RUN;
                    end
                end
                DONE: begin
                    if (bus.start || bus.stop) begin
                        st <= IDLE;
`ifdef ALARM_TIMEOUT_EN
                    end else if (bus.tick) begin
                        acnt <= acnt + 8'd1;
                        if (acnt == ALARM_LAST) begin
                            st <= IDLE;
                        end
`endif
                    end
                end
            endcase
        end
    end

    assign bus.digit_en  = en;
    assign bus.cnt_clear = clr;
    assign bus.running   = (st == RUN);
    assign bus.alarm     = (st == DONE);
    assign bus.state     = st;
endmodule

// File: tb/tb_timer_ctrl.sv
// Vector table plus scoreboard bench for timer_ctrl.
module tb_timer_ctrl;
    localparam int ND = 4;
`ifdef ALARM_TIMEOUT_EN
    localparam int AT = 3;
`else
    localparam int AT = 30;
`endif

    typedef struct {
        logic       rst;
        logic       tk;
        logic       sa;
        logic       so;
        logic [3:0] tc;
        logic [1:0] st;
        logic       clr;
        logic [3:0] en;
    } vec_t;

    logic clk;
    logic reset;
    int   nvec;
    int   nbad;
    vec_t tbl[$];
    vec_t exp_q[$];

    timer_ctrl_if #(.NUM_DIGITS(ND)) bus ();

    timer_ctrl #(
        .NUM_DIGITS (ND),
        .ALARM_TICKS(AT)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic apply(input vec_t v, input string name);
        vec_t e;
        logic run_e;
        logic alm_e;
        @(posedge clk);
        #1;
        reset     = v.rst;
        bus.tick  = v.tk;
        bus.start = v.sa;
        bus.stop  = v.so;
        bus.tc    = v.tc;
        exp_q.push_back(v);
        @(negedge clk);
        e     = exp_q.pop_front();
        run_e = (e.st == 2'b01);
        alm_e = (e.st == 2'b11);
        nvec++;
        if (bus.state !== e.st || bus.cnt_clear !== e.clr ||
            bus.digit_en !== e.en || bus.running !== run_e ||
            bus.alarm !== alm_e) begin
            nbad++;
            $display("FAIL %s: got st=%b clr=%b en=%b run=%b alm=%b want st=%b clr=%b en=%b run=%b alm=%b",
                     name, bus.state, bus.cnt_clear, bus.digit_en,
                     bus.running, bus.alarm, e.st, e.clr, e.en,
                     run_e, alm_e);
        end
    endtask

    initial begin
        nvec      = 0;
        nbad      = 0;
        reset     = 1'b1;
        bus.tick  = 1'b0;
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        bus.tc    = 4'h0;
        repeat (2) @(posedge clk);

        //            rst tk sa so tc     st     clr en
        tbl.push_back('{1, 0, 0, 0, 4'h0, 2'b00, 0, 4'b0000});
        tbl.push_back('{0, 1, 0, 0, 4'h0, 2'b00, 0, 4'b0000});
        tbl.push_back('{0, 0, 1, 0, 4'h0, 2'b00, 0, 4'b0000});
        tbl.push_back('{0, 1, 0, 0, 4'h0, 2'b01, 1, 4'b0000});
        tbl.push_back('{0, 0, 0, 0, 4'h0, 2'b01, 0, 4'b0000});
        tbl.push_back('{0, 1, 0, 0, 4'h3, 2'b01, 0, 4'b0111});
        tbl.push_back('{0, 1, 0, 0, 4'h0, 2'b01, 0, 4'b0001});
        tbl.push_back('{0, 0, 0, 0, 4'h0, 2'b01, 0, 4'b0000});
        tbl.push_back('{0, 1, 1, 0, 4'h1, 2'b01, 0, 4'b0011});
        tbl.push_back('{0, 1, 1, 1, 4'h0, 2'b01, 0, 4'b0001});
        tbl.push_back('{0, 1, 0, 0, 4'h0, 2'b10, 0, 4'b0000});
        tbl.push_back('{0, 0, 1, 0, 4'h0, 2'b10, 0, 4'b0000});
        tbl.push_back('{0, 1, 0, 0, 4'h0, 2'b01, 0, 4'b0001});
        tbl.push_back('{0, 1, 0, 0, 4'hf, 2'b01, 0, 4'b0000});
        tbl.push_back('{0, 0, 0, 0, 4'hf, 2'b11, 0, 4'b0000});
        tbl.push_back('{0, 1, 0, 0, 4'hf, 2'b11, 0, 4'b0000});
        tbl.push_back('{0, 0, 0, 1, 4'hf, 2'b11, 0, 4'b0000});
        tbl.push_back('{0, 0, 1, 0, 4'h0, 2'b00, 0, 4'b0000});
        tbl.push_back('{0, 1, 0, 0, 4'h0, 2'b01, 1, 4'b0000});
        tbl.push_back('{0, 0, 0, 1, 4'h0, 2'b01, 0, 4'b0000});
        tbl.push_back('{0, 0, 0, 1, 4'h0, 2'b10, 0, 4'b0000});
        tbl.push_back('{0, 0, 0, 0, 4'h0, 2'b00, 0, 4'b0000});
        tbl.push_back('{0, 0, 1, 0, 4'hf, 2'b00, 0, 4'b0000});
        tbl.push_back('{0, 1, 0, 0, 4'hf, 2'b01, 1, 4'b0000});
        tbl.push_back('{0, 1, 0, 0, 4'hf, 2'b01, 0, 4'b0000});
        tbl.push_back('{0, 0, 1, 0, 4'h0, 2'b11, 0, 4'b0000});
        tbl.push_back('{0, 0, 1, 0, 4'h0, 2'b00, 0, 4'b0000});
        tbl.push_back('{0, 1, 0, 0, 4'h0, 2'b01, 1, 4'b0000});
        tbl.push_back('{0, 0, 1, 0, 4'h0, 2'b01, 0, 4'b0000});
        tbl.push_back('{0, 0, 0, 1, 4'h0, 2'b01, 0, 4'b0000});
        tbl.push_back('{1, 1, 1, 0, 4'h0, 2'b10, 0, 4'b0000});
        tbl.push_back('{0, 0, 0, 0, 4'h0, 2'b00, 0, 4'b0000});
        tbl.push_back('{0, 0, 1, 0, 4'h0, 2'b00, 0, 4'b0000});
        tbl.push_back('{1, 1, 0, 0, 4'h0, 2'b01, 1, 4'b0000});
        tbl.push_back('{0, 0, 0, 0, 4'h0, 2'b00, 0, 4'b0000});

        foreach (tbl[i]) apply(tbl[i], $sformatf("row%0d", i));

        // Reach DONE, then exercise the alarm exit path.
        apply('{0, 0, 1, 0, 4'hf, 2'b00, 0, 4'b0000}, "seq_start");
        apply('{0, 0, 0, 0, 4'hf, 2'b01, 1, 4'b0000}, "seq_clear");
        apply('{0, 1, 0, 0, 4'hf, 2'b01, 0, 4'b0000}, "seq_zero");
`ifdef ALARM_TIMEOUT_EN
        apply('{0, 1, 0, 0, 4'hf, 2'b11, 0, 4'b0000}, "alarm_t1");
        apply('{0, 1, 0, 0, 4'hf, 2'b11, 0, 4'b0000}, "alarm_t2");
        apply('{0, 1, 0, 0, 4'hf, 2'b11, 0, 4'b0000}, "alarm_t3");
        apply('{0, 0, 0, 0, 4'hf, 2'b00, 0, 4'b0000}, "alarm_idle");
`else
        for (int k = 0; k < 300; k++) begin
            apply('{0, 1, 0, 0, 4'hf, 2'b11, 0, 4'b0000},
                  $sformatf("alarm_hold%0d", k));
        end
        apply('{0, 0, 0, 1, 4'hf, 2'b11, 0, 4'b0000}, "alarm_stop");
        apply('{0, 0, 0, 0, 4'hf, 2'b00, 0, 4'b0000}, "alarm_idle");
`endif

        if (exp_q.size() != 0) begin
            nbad++;
            $display("FAIL scoreboard: %0d left, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end
endmodule
